// File: rtl/gvt_controller.sv
// Epoch-driven GVT sequencer: drains dispatch, snapshots core/queue timestamps, min-reduces, publishes.
// Define GVT_FOSSIL_EN to include the fossil-collection request path (FOSSIL state, last_fc, fc_req/fc_time).
module gvt_controller #(
  parameter int unsigned NUM_CORE = 4,
  parameter int unsigned TIME_WID = 16,
  parameter int unsigned EPOCH    = 64,
  parameter int unsigned FC_DELTA = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CORE-1:0]          core_start,
  input  logic [TIME_WID*NUM_CORE-1:0] core_time,
  input  logic [NUM_CORE-1:0]          core_done,
  input  logic [TIME_WID-1:0]          next_event,
  input  logic                         queue_empty,
  input  logic                         dispatch_busy,
  output logic                         dispatch_hold,
  output logic [TIME_WID-1:0]          gvt,
  output logic                         gvt_vld,
  output logic                         gvt_err,
  output logic                         fc_req,
  output logic [TIME_WID-1:0]          fc_time,
  input  logic                         fc_ack
);

  localparam int unsigned LVL  = $clog2(NUM_CORE + 1);
  localparam int unsigned LEAF = 1 << LVL;
  localparam int unsigned NODE = 2 * LEAF - 1;
  localparam int unsigned EW   = $clog2(EPOCH);
  localparam int unsigned RW   = $clog2(LVL) + 1;

  typedef enum logic [2:0] {IDLE, DRAIN, SNAP, REDUCE, PUBLISH, FOSSIL} state_t;

  state_t               state, state_nx;
  logic [EW-1:0]        epoch_cnt;
  logic [RW-1:0]        red_cnt;
  logic [NUM_CORE-1:0]  act_vld;
  logic [TIME_WID-1:0]  act_time [NUM_CORE];
  logic                 node_vld  [NODE];
  logic [TIME_WID-1:0]  node_time [NODE];
  logic                 gvt_adv;
  logic                 fc_due;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // The DRAIN cycle itself is epoch cycle EPOCH-1, so IDLE leaves one count early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epoch_cnt <= '0;
      red_cnt   <= '0;
    end else begin
      epoch_cnt <= (state == IDLE)   ? epoch_cnt + 1'b1 : '0;
      red_cnt   <= (state == REDUCE) ? red_cnt + 1'b1   : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_vld <= '0;
      for (int unsigned i = 0; i < NUM_CORE; i++) act_time[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CORE; i++) begin
        if (core_start[i]) begin
          act_vld[i]  <= 1'b1;
          act_time[i] <= core_time[i*TIME_WID +: TIME_WID];
        end else if (core_done[i]) begin
          act_vld[i]  <= 1'b0;
        end
      end
    end
  end

  // Heap-ordered min tree: leaves at LEAF-1.., every internal node registered, root at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < NODE; n++) begin
        node_vld[n]  <= 1'b0;
        node_time[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < LEAF - 1; n++) begin
        node_vld[n]  <= node_vld[2*n+1] | node_vld[2*n+2];
        node_time[n] <= (node_vld[2*n+1] &&
                         (!node_vld[2*n+2] || node_time[2*n+1] <= node_time[2*n+2]))
                        ? node_time[2*n+1] : node_time[2*n+2];
      end
      if (state == SNAP) begin
        for (int unsigned k = 0; k < NUM_CORE; k++) begin
          node_vld[LEAF-1+k]  <= act_vld[k];
          node_time[LEAF-1+k] <= act_time[k];
        end
        node_vld[LEAF-1+NUM_CORE]  <= ~queue_empty;
        node_time[LEAF-1+NUM_CORE] <= next_event;
      end
    end
  end

  assign gvt_adv = node_vld[0] && (node_time[0] >= gvt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gvt     <= '0;
      gvt_vld <= 1'b0;
      gvt_err <= 1'b0;
    end else begin
      gvt_vld <= 1'b0;
      if (state == PUBLISH) begin
        if (gvt_adv) begin
          gvt     <= node_time[0];
          gvt_vld <= 1'b1;
        end else if (node_vld[0]) begin
          gvt_err <= 1'b1;
        end
      end
    end
  end

`ifdef GVT_FOSSIL_EN
  logic [TIME_WID-1:0] last_fc;
  logic [TIME_WID-1:0] gvt_nx;

  // Decided in PUBLISH, so it must see the value gvt is about to take.
  assign gvt_nx = gvt_adv ? node_time[0] : gvt;
  assign fc_due = (gvt_nx - last_fc) >= TIME_WID'(FC_DELTA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          last_fc <= '0;
    else if (state == FOSSIL && fc_ack) last_fc <= gvt;
  end
`else
  localparam int unsigned FC_DELTA_UNUSED = FC_DELTA;
  logic fc_ack_unused;
  assign fc_ack_unused = fc_ack;
  assign fc_due        = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (epoch_cnt == EW'(EPOCH - 2)) state_nx = DRAIN;
      DRAIN:   if (!dispatch_busy) state_nx = SNAP;
      SNAP:    state_nx = REDUCE;
      REDUCE:  if (red_cnt == RW'(LVL - 1)) state_nx = PUBLISH;
      PUBLISH: state_nx = fc_due ? FOSSIL : IDLE;
`ifdef GVT_FOSSIL_EN
      FOSSIL:  if (fc_ack) state_nx = IDLE;
`else
      FOSSIL:  state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dispatch_hold = (state == DRAIN) || (state == SNAP);
    fc_req        = 1'b0;
    fc_time       = '0;
`ifdef GVT_FOSSIL_EN
    if (state == FOSSIL) begin
      fc_req  = 1'b1;
      fc_time = gvt;
    end
`endif
  end

endmodule

// File: tb/tb_gvt_controller.sv
// Directed bench for gvt_controller (NUM_CORE=4, TIME_WID=16, EPOCH=64, FC_DELTA=256).
// Cycle k is the interval after the k-th rising edge following reset release; outputs sampled on falling edges.
module tb_gvt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  core_start, core_done;
  logic [63:0] core_time;
  logic [15:0] next_event;
  logic        queue_empty, dispatch_busy;
  logic        dispatch_hold, gvt_vld, gvt_err, fc_req, fc_ack;
  logic [15:0] gvt, fc_time;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int hold_rise, hold_fall, vld_at, vld_cnt, fc_at, fc_cnt, fc_time_bad;
  logic [15:0] fc_time_seen;

  gvt_controller #(.NUM_CORE(4), .TIME_WID(16), .EPOCH(64), .FC_DELTA(256)) dut (
    .clk(clk), .rst(rst), .core_start(core_start), .core_time(core_time),
    .core_done(core_done), .next_event(next_event), .queue_empty(queue_empty),
    .dispatch_busy(dispatch_busy), .dispatch_hold(dispatch_hold), .gvt(gvt),
    .gvt_vld(gvt_vld), .gvt_err(gvt_err), .fc_req(fc_req), .fc_time(fc_time),
    .fc_ack(fc_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    hold_rise = -1; hold_fall = -1; vld_at = -1; vld_cnt = 0;
    fc_at = -1; fc_cnt = 0; fc_time_bad = 0; fc_time_seen = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    core_start = '0; core_done = '0; core_time = '0;
    next_event = '0; queue_empty = 1'b1; dispatch_busy = 1'b0; fc_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic start_core(input int c, input logic [15:0] t);
    core_start[c] = 1'b1;
    core_time[c*16 +: 16] = t;
    @(negedge clk);
    core_start = '0;
  endtask

  task automatic watch_until(input int last);
    while (cyc < last) begin
      @(negedge clk);
      if (dispatch_hold && hold_rise < 0) hold_rise = cyc;
      if (!dispatch_hold && hold_rise >= 0 && hold_fall < 0) hold_fall = cyc;
      if (gvt_vld) begin
        vld_cnt++;
        if (vld_at < 0) vld_at = cyc;
      end
      if (fc_req) begin
        fc_cnt++;
        if (fc_at < 0) begin fc_at = cyc; fc_time_seen = fc_time; end
      end else if (fc_time !== 16'd0) begin
        fc_time_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_run++; if (gvt !== 16'd0) begin n_fail++; $display("FAIL reset_gvt: got %0d want 0", gvt); end
    n_run++; if (gvt_vld !== 1'b0) begin n_fail++; $display("FAIL reset_gvt_vld: got %b want 0", gvt_vld); end
    n_run++; if (gvt_err !== 1'b0) begin n_fail++; $display("FAIL reset_gvt_err: got %b want 0", gvt_err); end
    n_run++; if (dispatch_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", dispatch_hold); end
    n_run++; if (fc_req !== 1'b0) begin n_fail++; $display("FAIL reset_fc_req: got %b want 0", fc_req); end
    n_run++; if (fc_time !== 16'd0) begin n_fail++; $display("FAIL reset_fc_time: got %0d want 0", fc_time); end
  endtask

  task automatic test_baseline();
    do_reset();
    next_event = 16'd20; queue_empty = 1'b0;
    core_time = {16'd9, 16'd12, 16'd7, 16'd10};
    core_start = 4'hF;
    @(negedge clk);
    core_start = '0;
    watch_until(75);
    n_run++; if (hold_rise !== 63) begin n_fail++; $display("FAIL base_hold_rise: got %0d want 63", hold_rise); end
    n_run++; if (hold_fall !== 65) begin n_fail++; $display("FAIL base_hold_fall: got %0d want 65", hold_fall); end
    n_run++; if (vld_at !== 69) begin n_fail++; $display("FAIL base_vld_at: got %0d want 69", vld_at); end
    n_run++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL base_vld_cnt: got %0d want 1", vld_cnt); end
    n_run++; if (gvt !== 16'd7) begin n_fail++; $display("FAIL base_gvt: got %0d want 7", gvt); end
    n_run++; if (gvt_err !== 1'b0) begin n_fail++; $display("FAIL base_err: got %b want 0", gvt_err); end
  endtask

  task automatic test_idle();
    do_reset();
    watch_until(75);
    n_run++; if (hold_rise !== 63) begin n_fail++; $display("FAIL idle_hold_rise: got %0d want 63", hold_rise); end
    n_run++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL idle_vld_cnt: got %0d want 0", vld_cnt); end
    n_run++; if (gvt !== 16'd0) begin n_fail++; $display("FAIL idle_gvt: got %0d want 0", gvt); end
    start_core(0, 16'd100);
    clear_obs();
    watch_until(145);
    n_run++; if (hold_rise !== 132) begin n_fail++; $display("FAIL idle_next_rise: got %0d want 132", hold_rise); end
    n_run++; if (vld_at !== 138) begin n_fail++; $display("FAIL idle_next_vld: got %0d want 138", vld_at); end
    n_run++; if (gvt !== 16'd100) begin n_fail++; $display("FAIL idle_next_gvt: got %0d want 100", gvt); end
  endtask

  task automatic test_drain_stall();
    do_reset();
    start_core(0, 16'd5);
    watch_until(63);
    dispatch_busy = 1'b1;
    watch_until(73);
    dispatch_busy = 1'b0;
    watch_until(85);
    n_run++; if (hold_rise !== 63) begin n_fail++; $display("FAIL stall_hold_rise: got %0d want 63", hold_rise); end
    n_run++; if (hold_fall !== 75) begin n_fail++; $display("FAIL stall_hold_fall: got %0d want 75", hold_fall); end
    n_run++; if (vld_at !== 79) begin n_fail++; $display("FAIL stall_vld_at: got %0d want 79", vld_at); end
    n_run++; if (gvt !== 16'd5) begin n_fail++; $display("FAIL stall_gvt: got %0d want 5", gvt); end
  endtask

  task automatic test_regression();
    do_reset();
    start_core(1, 16'd50);
    watch_until(75);
    n_run++; if (gvt !== 16'd50) begin n_fail++; $display("FAIL regr_first_gvt: got %0d want 50", gvt); end
    start_core(1, 16'd40);
    clear_obs();
    watch_until(145);
    n_run++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL regr_vld_cnt: got %0d want 0", vld_cnt); end
    n_run++; if (gvt !== 16'd50) begin n_fail++; $display("FAIL regr_gvt_kept: got %0d want 50", gvt); end
    n_run++; if (gvt_err !== 1'b1) begin n_fail++; $display("FAIL regr_err_set: got %b want 1", gvt_err); end
    start_core(1, 16'd70);
    clear_obs();
    watch_until(215);
    n_run++; if (vld_at !== 207) begin n_fail++; $display("FAIL regr_next_vld: got %0d want 207", vld_at); end
    n_run++; if (gvt !== 16'd70) begin n_fail++; $display("FAIL regr_next_gvt: got %0d want 70", gvt); end
    n_run++; if (gvt_err !== 1'b1) begin n_fail++; $display("FAIL regr_err_sticky: got %b want 1", gvt_err); end
  endtask

  task automatic test_start_done_same_cycle();
    do_reset();
    next_event = 16'd35; queue_empty = 1'b0;
    start_core(2, 16'd25);
    watch_until(10);
    core_done[2] = 1'b1;
    core_start[2] = 1'b1;
    core_time[2*16 +: 16] = 16'd30;
    watch_until(11);
    core_done = '0; core_start = '0;
    watch_until(75);
    n_run++; if (vld_at !== 69) begin n_fail++; $display("FAIL sim_vld_at: got %0d want 69", vld_at); end
    n_run++; if (gvt !== 16'd30) begin n_fail++; $display("FAIL sim_gvt: got %0d want 30", gvt); end
  endtask

  task automatic test_snap_capture();
    do_reset();
    start_core(0, 16'd20);
    watch_until(64);
    n_run++; if (dispatch_hold !== 1'b1) begin n_fail++; $display("FAIL snap_hold: got %b want 1", dispatch_hold); end
    core_start[0] = 1'b1;
    core_time[15:0] = 16'd25;
    watch_until(65);
    core_start = '0;
    watch_until(75);
    n_run++; if (gvt !== 16'd20) begin n_fail++; $display("FAIL snap_excluded: got %0d want 20", gvt); end
    clear_obs();
    watch_until(145);
    n_run++; if (gvt !== 16'd25) begin n_fail++; $display("FAIL snap_tracked: got %0d want 25", gvt); end
  endtask

  task automatic test_reset_mid_round();
    do_reset();
    start_core(0, 16'd10);
    watch_until(75);
    n_run++; if (gvt !== 16'd10) begin n_fail++; $display("FAIL mid_pre_gvt: got %0d want 10", gvt); end
    watch_until(133);
    rst = 1'b1;
    #1;
    n_run++; if (dispatch_hold !== 1'b0) begin n_fail++; $display("FAIL mid_hold: got %b want 0", dispatch_hold); end
    n_run++; if (gvt !== 16'd0) begin n_fail++; $display("FAIL mid_gvt: got %0d want 0", gvt); end
  endtask

  task automatic test_fossil();
    do_reset();
    start_core(0, 16'd300);
`ifdef GVT_FOSSIL_EN
    watch_until(73);
    fc_ack = 1'b1;
    watch_until(74);
    fc_ack = 1'b0;
    n_run++; if (fc_at !== 69) begin n_fail++; $display("FAIL fc_rise: got %0d want 69", fc_at); end
    n_run++; if (fc_time_seen !== 16'd300) begin n_fail++; $display("FAIL fc_time: got %0d want 300", fc_time_seen); end
    n_run++; if (fc_cnt !== 5) begin n_fail++; $display("FAIL fc_high_cycles: got %0d want 5", fc_cnt); end
    n_run++; if (fc_req !== 1'b0) begin n_fail++; $display("FAIL fc_drop: got %b want 0", fc_req); end
    start_core(0, 16'd400);
    clear_obs();
    watch_until(150);
    n_run++; if (vld_at !== 143) begin n_fail++; $display("FAIL fc_r2_vld: got %0d want 143", vld_at); end
    n_run++; if (gvt !== 16'd400) begin n_fail++; $display("FAIL fc_r2_gvt: got %0d want 400", gvt); end
    n_run++; if (fc_cnt !== 0) begin n_fail++; $display("FAIL fc_r2_none: got %0d want 0", fc_cnt); end
    fc_ack = 1'b1;
    start_core(0, 16'd600);
    clear_obs();
    watch_until(220);
    fc_ack = 1'b0;
    n_run++; if (fc_at !== 212) begin n_fail++; $display("FAIL fc_r3_rise: got %0d want 212", fc_at); end
    n_run++; if (fc_cnt !== 1) begin n_fail++; $display("FAIL fc_r3_same_ack: got %0d want 1", fc_cnt); end
    n_run++; if (fc_time_seen !== 16'd600) begin n_fail++; $display("FAIL fc_r3_time: got %0d want 600", fc_time_seen); end
    start_core(0, 16'd900);
    watch_until(282);
    n_run++; if (fc_req !== 1'b1) begin n_fail++; $display("FAIL fc_r4_req: got %b want 1", fc_req); end
    rst = 1'b1;
    #1;
    n_run++; if (fc_req !== 1'b0) begin n_fail++; $display("FAIL fc_abandon_req: got %b want 0", fc_req); end
    n_run++; if (fc_time !== 16'd0) begin n_fail++; $display("FAIL fc_abandon_time: got %0d want 0", fc_time); end
`else
    fc_ack = 1'b1;
    watch_until(140);
    fc_ack = 1'b0;
    n_run++; if (vld_at !== 69) begin n_fail++; $display("FAIL nofc_vld: got %0d want 69", vld_at); end
    n_run++; if (gvt !== 16'd300) begin n_fail++; $display("FAIL nofc_gvt: got %0d want 300", gvt); end
    n_run++; if (fc_cnt !== 0) begin n_fail++; $display("FAIL nofc_req: got %0d want 0", fc_cnt); end
    n_run++; if (hold_rise !== 63) begin n_fail++; $display("FAIL nofc_rise: got %0d want 63", hold_rise); end
    clear_obs();
    watch_until(140);
`endif
    n_run++; if (fc_time_bad !== 0) begin n_fail++; $display("FAIL fc_time_idle: got %0d want 0", fc_time_bad); end
  endtask

  initial begin
    rst = 1'b1;
    core_start = '0; core_done = '0; core_time = '0;
    next_event = '0; queue_empty = 1'b1; dispatch_busy = 1'b0; fc_ack = 1'b0;
    clear_obs();
    test_reset();
    test_baseline();
    test_idle();
    test_drain_stall();
    test_regression();
    test_start_done_same_cycle();
    test_snap_capture();
    test_reset_mid_round();
    test_fossil();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/gvt_controller.md
# gvt_controller

Sequences global-virtual-time (GVT) computation for the PDES engine. On a fixed epoch it freezes event dispatch, snapshots per-core active timestamps and the event-queue head, reduces them to a minimum, and publishes a monotonic GVT to the cores. When GVT has advanced far enough, it requests fossil collection. It sits between the dispatcher, the cores and the event-queue/memory manager, and replaces free-running combinational GVT.

## Interface
- NUM_CORE, 4, number of cores; power of two, ≥2
- TIME_WID, 16, timestamp width, unsigned
- EPOCH, 64, cycles from end of one GVT round to start of the next; ≥4
- FC_DELTA, 256, minimum GVT advance since the last fossil collection before a new one is issued

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- core_start  in  NUM_CORE  pulse: core i began an event at core_time slice i
- core_time  in  TIME_WID*NUM_CORE  per-core event timestamp; valid with core_start
- core_done  in  NUM_CORE  pulse: core i finished its event
- next_event  in  TIME_WID  event-queue head timestamp
- queue_empty  in  1  queue holds no events; next_event ignored
- dispatch_busy  in  1  dispatcher has an event in flight to a core
- dispatch_hold  out  1  freezes new dispatch
- gvt  out  TIME_WID  published GVT
- gvt_vld  out  1  one-cycle pulse when gvt updates
- gvt_err  out  1  sticky: computed minimum was below the current gvt
- fc_req  out  1  fossil-collection request, held until fc_ack
- fc_time  out  TIME_WID  collect everything strictly older than this
- fc_ack  in  1  fossil collection accepted

## Operation
- Per-core tracker: act_vld[i] and act_time[i]. core_start sets act_vld and loads act_time. core_done clears act_vld. If both pulse in the same cycle, start wins: done closes the old event and start opens the new one.
- States:
  - IDLE: epoch counter counts up. At EPOCH−1, go to DRAIN and assert dispatch_hold.
  - DRAIN: wait for dispatch_busy=0.
  - SNAP: register act_vld, act_time and next_event. Treat the queue head as invalid when queue_empty=1.
  - REDUCE: registered binary min tree over the valid entries plus the queue head. One pipeline register per log2(NUM_CORE+1) level, rounded up. A level with neither input valid yields invalid.
  - PUBLISH: one cycle.
    - If the result is invalid (all cores idle and queue empty), gvt is unchanged and there is no pulse.
    - Else if result ≥ gvt, load gvt and pulse gvt_vld.
    - Else set gvt_err, keep gvt, no pulse.
    - Go to FOSSIL if the fossil condition holds, else go to IDLE and clear the epoch counter.
  - FOSSIL: hold fc_req=1 with fc_time=gvt until fc_ack. Then record last_fc=gvt and go to IDLE.
- dispatch_hold is asserted from the DRAIN entry through the end of SNAP and deasserted in REDUCE.
- Fossil condition: gvt − last_fc ≥ FC_DELTA, as an unsigned TIME_WID subtraction. last_fc resets to 0. No wrap-around: timestamps never wrap within a run.
- Tracker updates continue in every state. The snapshot taken in SNAP is the only input to the reduction.

## Timing
- Reset values:
  - gvt=0, gvt_vld=0, gvt_err=0, dispatch_hold=0, fc_req=0, fc_time=0
  - state IDLE, epoch counter 0, all act_vld=0, last_fc=0
- Round latency with dispatch_busy=0: 1 DRAIN + 1 SNAP + L REDUCE + 1 PUBLISH cycles, where L=ceil(log2(NUM_CORE+1)).
  - NUM_CORE=4: dispatch_hold rises at epoch cycle EPOCH−1 and gvt_vld pulses 2+L+1=6 cycles later.
- core_start in the SNAP cycle is captured in act_time but not in the snapshot.
- fc_ack may arrive in the same cycle fc_req rises. fc_req drops the cycle after fc_ack is sampled high.
- Reset mid-round: all outputs return to reset values immediately. An outstanding fc_req is abandoned without waiting for ack.

## Configuration
- GVT_FOSSIL_EN:
  - Defined: FOSSIL state, last_fc and the fc_req/fc_time logic are present.
  - Undefined: fc_req and fc_time are tied to 0, fc_ack is ignored, and PUBLISH always returns to IDLE.

## Test plan
- Baseline: NUM_CORE=4, cores 0–3 start at times 10, 7, 12, 9, next_event=20, dispatch_busy=0 → dispatch_hold high cycle 63, gvt=7 with gvt_vld pulse 6 cycles later, dispatch_hold low from cycle 65.
- Idle system: no cores active, queue_empty=1 → no gvt_vld, gvt stays 0, the next round proceeds normally.
- Drain stall: dispatch_busy held high for 10 cycles after hold → DRAIN lasts 10 cycles and gvt_vld is delayed by exactly 10.
- Regression: gvt=50, then core 1 starts at 40 → gvt_err=1, gvt stays 50, no gvt_vld; gvt_err persists until reset.
- Simultaneous start/done: core 2 done and start(30) in one cycle with other cores idle and queue head 35 → next round gvt=30.
- Fossil (macro defined, FC_DELTA=256): gvt advances 0→300 → fc_req with fc_time=300. With fc_ack delayed 5 cycles, fc_req stays high 5 cycles. The following round at gvt=400 gives no fc_req, since 400−300<256.
